// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, instruction field helpers and the per-cycle pipeline action type.
package pipe_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_W   = 5;

    typedef logic [OPC_W-1:0] opcode_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    // What the whole pipeline does this cycle, in priority order.
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_FLUSH,
        ACT_STALL,
        ACT_ADVANCE
    } act_e;

    function automatic opcode_t opcode_of(input logic [31:0] ir);
        return ir[OPC_LSB +: OPC_W];
    endfunction

    function automatic reg_idx_t rd_of(input logic [31:0] ir);
        return ir[RD_LSB +: REG_W];
    endfunction

    function automatic reg_idx_t rs1_of(input logic [31:0] ir);
        return ir[RS1_LSB +: REG_W];
    endfunction

    function automatic reg_idx_t rs2_of(input logic [31:0] ir);
        return ir[RS2_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a load in stage 1 whose destination is read by the instruction in stage 0.
//   ir0    in  32 : instruction in stage 0 (RR)
//   ir1    in  32 : instruction in stage 1 (ALU)
//   valid  in  2  : valid bits of stages 1..0
//   hazard out 1  : load-use hazard present
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [31:0] ir0,
    input  logic [31:0] ir1,
    input  logic [1:0]  valid,
    output logic        hazard
);

    opcode_t  op0;
    reg_idx_t rd1;
    logic     use_rs1;
    logic     use_rs2;

    assign op0 = opcode_of(ir0);
    assign rd1 = rd_of(ir1);

    // U-type and JAL carry immediate bits in the rs1 field; only R/S/B types read rs2.
    assign use_rs1 = !(op0 inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign use_rs2 = op0 inside {OPC_OP, OPC_STORE, OPC_BRANCH};

    assign hazard = &valid && opcode_of(ir1) == OPC_LOAD && rd1 != '0 &&
                    ((use_rs1 && rs1_of(ir0) == rd1) || (use_rs2 && rs2_of(ir0) == rd1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: PC/IR pipeline registers with load-use stalling and branch-redirect squashing.
//   clock     in  1             : clock, rising edge
//   reset     in  1             : asynchronous active-low reset
//   halt      in  1             : freeze all state
//   if_valid  in  1             : fetch present
//   if_pc     in  XLEN          : fetched PC
//   if_ir     in  ILEN          : fetched instruction
//   if_ready  out 1             : fetch accepted this cycle
//   flush     in  1             : redirect from stage FLUSH_STAGE
//   valid_o   out STAGES        : per-stage valid bits
//   pc_o      out STAGES*XLEN   : per-stage PCs, stage k at [k*XLEN +: XLEN]
//   ir_o      out STAGES*ILEN   : per-stage IRs, stage k at [k*ILEN +: ILEN]
//   stall_o   out 1             : load-use stall applied this cycle
//   stall_cnt out CNT_W         : saturating stall-cycle count
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES      = 4,
    parameter int XLEN        = 32,
    parameter int ILEN        = 32,
    parameter int FLUSH_STAGE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     halt,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [ILEN-1:0]          if_ir,
    output logic                     if_ready,
    input  logic                     flush,
    output logic [STAGES-1:0]        valid_o,
    output logic [STAGES*XLEN-1:0]   pc_o,
    output logic [STAGES*ILEN-1:0]   ir_o,
    output logic                     stall_o,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [STAGES-1:0] valid;
    logic [XLEN-1:0]   pc [STAGES];
    logic [ILEN-1:0]   ir [STAGES];
    logic              hazard;
    act_e              act;

    hazard_detect u_hazard (
        .ir0    (ir[0]),
        .ir1    (ir[1]),
        .valid  (valid[1:0]),
        .hazard (hazard)
    );

    // A flush outranks a hazard: the stalled instruction is being squashed anyway.
    assign act      = halt ? ACT_HOLD : flush ? ACT_FLUSH : hazard ? ACT_STALL : ACT_ADVANCE;
    assign if_ready = act == ACT_FLUSH || act == ACT_ADVANCE;
    assign stall_o  = act == ACT_STALL;
    assign valid_o  = valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic            v_q;
        logic [XLEN-1:0] pc_q;
        logic [ILEN-1:0] ir_q;
        logic            ld;
        logic            bub;
        logic            src_v;
        logic [XLEN-1:0] src_pc;
        logic [ILEN-1:0] src_ir;

        if (k == 0) begin : g_head
            // Stage 0 holds on a stall; a missing fetch enters as a bubble.
            assign ld     = act == ACT_ADVANCE && if_valid;
            assign bub    = act == ACT_FLUSH || (act == ACT_ADVANCE && !if_valid);
            assign src_v  = 1'b1;
            assign src_pc = if_pc;
            assign src_ir = if_ir;
        end else begin : g_body
            assign ld     = act == ACT_ADVANCE || (act == ACT_FLUSH && k > FLUSH_STAGE) ||
                            (act == ACT_STALL && k >= 2);
            assign bub    = (act == ACT_FLUSH && k <= FLUSH_STAGE) || (act == ACT_STALL && k == 1);
            assign src_v  = valid[k-1];
            assign src_pc = pc[k-1];
            assign src_ir = ir[k-1];
        end

        // Bubbles keep their old PC so downstream debug still sees where the slot came from.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                v_q  <= 1'b0;
                pc_q <= '0;
                ir_q <= NOP;
            end else if (bub) begin
                v_q  <= 1'b0;
                ir_q <= NOP;
            end else if (ld) begin
                v_q  <= src_v;
                pc_q <= src_pc;
                ir_q <= src_ir;
            end
        end

        assign valid[k]                = v_q;
        assign pc[k]                   = pc_q;
        assign ir[k]                   = ir_q;
        assign pc_o[k*XLEN +: XLEN]    = pc_q;
        assign ir_o[k*ILEN +: ILEN]    = ir_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (act == ACT_STALL && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, table-driven checks of pipe_ctrl in the default and a deep-pipeline configuration.
module tb_pipe_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] A1    = 32'h0010_0093;
    localparam logic [31:0] A2    = 32'h0020_0093;
    localparam logic [31:0] A3    = 32'h0030_0093;
    localparam logic [31:0] A4    = 32'h0040_0093;
    localparam logic [31:0] A5    = 32'h0050_0093;
    localparam logic [31:0] A6    = 32'h0060_0093;
    localparam logic [31:0] LW5   = 32'h0000_A283;
    localparam logic [31:0] ADD   = 32'h0022_8333;
    localparam logic [31:0] LW0   = 32'h0000_A003;
    localparam logic [31:0] ADD00 = 32'h0000_0333;
    localparam logic [31:0] LUI   = 32'h0002_82B7;
    localparam logic [31:0] AI5   = 32'h0050_0313;

    logic         clock;
    logic         reset;
    logic         halt, flush, if_valid, if_ready, stall_o;
    logic [31:0]  if_pc, if_ir;
    logic [3:0]   valid_o;
    logic [127:0] pc_o, ir_o;
    logic [15:0]  stall_cnt;

    logic         h2, f2, iv2, rdy2, stl2;
    logic [31:0]  pc_in2, ir_in2;
    logic [5:0]   v2;
    logic [191:0] pco2, iro2;
    logic [1:0]   cnt2;

    int checks = 0;
    int failures = 0;

    pipe_ctrl dut (
        .clock(clock), .reset(reset), .halt(halt), .if_valid(if_valid), .if_pc(if_pc),
        .if_ir(if_ir), .if_ready(if_ready), .flush(flush), .valid_o(valid_o), .pc_o(pc_o),
        .ir_o(ir_o), .stall_o(stall_o), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.STAGES(6), .FLUSH_STAGE(3), .CNT_W(2)) dut6 (
        .clock(clock), .reset(reset), .halt(h2), .if_valid(iv2), .if_pc(pc_in2),
        .if_ir(ir_in2), .if_ready(rdy2), .flush(f2), .valid_o(v2), .pc_o(pco2),
        .ir_o(iro2), .stall_o(stl2), .stall_cnt(cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        halt, flush, iv;
        logic [31:0] pc, ir;
        logic        rdy, stl;
        logic [3:0]  v;
        logic [31:0] ir0, ir1, ir2, pc3;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input logic h, f, iv, input logic [31:0] pc, ir,
                                input logic rdy, stl, input logic [3:0] v,
                                input logic [31:0] ir0, ir1, ir2, pc3, input logic [15:0] cnt);
        vec_t r;
        r.halt = h; r.flush = f; r.iv = iv; r.pc = pc; r.ir = ir;
        r.rdy = rdy; r.stl = stl; r.v = v;
        r.ir0 = ir0; r.ir1 = ir1; r.ir2 = ir2; r.pc3 = pc3; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply(input int i, input vec_t t);
        halt = t.halt; flush = t.flush; if_valid = t.iv; if_pc = t.pc; if_ir = t.ir;
        #1;
        chk($sformatf("v%0d_if_ready", i), 128'(if_ready), 128'(t.rdy));
        chk($sformatf("v%0d_stall_o", i), 128'(stall_o), 128'(t.stl));
        @(posedge clock);
        @(negedge clock);
        chk($sformatf("v%0d_valid", i), 128'(valid_o), 128'(t.v));
        chk($sformatf("v%0d_ir0", i), 128'(ir_o[31:0]), 128'(t.ir0));
        chk($sformatf("v%0d_ir1", i), 128'(ir_o[63:32]), 128'(t.ir1));
        chk($sformatf("v%0d_ir2", i), 128'(ir_o[95:64]), 128'(t.ir2));
        chk($sformatf("v%0d_pc3", i), 128'(pc_o[127:96]), 128'(t.pc3));
        chk($sformatf("v%0d_cnt", i), 128'(stall_cnt), 128'(t.cnt));
    endtask

    task automatic step2(input logic f, iv, input logic [31:0] pc, ir);
        f2 = f; iv2 = iv; pc_in2 = pc; ir_in2 = ir;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        //              h f iv pc      ir     rdy stl v        ir0    ir1    ir2    pc3     cnt
        tbl[0]  = mk(0,0,1,32'h00,A1,    1,0,4'b0001,A1,   NOP,  NOP,  32'h00,0);
        tbl[1]  = mk(0,0,1,32'h04,A2,    1,0,4'b0011,A2,   A1,   NOP,  32'h00,0);
        tbl[2]  = mk(0,0,1,32'h08,A3,    1,0,4'b0111,A3,   A2,   A1,   32'h00,0);
        tbl[3]  = mk(0,0,1,32'h0C,A4,    1,0,4'b1111,A4,   A3,   A2,   32'h00,0);
        tbl[4]  = mk(0,0,1,32'h10,A5,    1,0,4'b1111,A5,   A4,   A3,   32'h04,0);
        tbl[5]  = mk(0,0,1,32'h14,A6,    1,0,4'b1111,A6,   A5,   A4,   32'h08,0);
        tbl[6]  = mk(0,0,1,32'h18,LW5,   1,0,4'b1111,LW5,  A6,   A5,   32'h0C,0);
        tbl[7]  = mk(0,0,1,32'h1C,ADD,   1,0,4'b1111,ADD,  LW5,  A6,   32'h10,0);
        tbl[8]  = mk(0,0,1,32'h20,A1,    0,1,4'b1101,ADD,  NOP,  LW5,  32'h14,1);
        tbl[9]  = mk(0,0,1,32'h20,A1,    1,0,4'b1011,A1,   ADD,  NOP,  32'h18,1);
        tbl[10] = mk(0,0,1,32'h24,LW0,   1,0,4'b0111,LW0,  A1,   ADD,  32'h18,1);
        tbl[11] = mk(0,0,1,32'h28,ADD00, 1,0,4'b1111,ADD00,LW0,  A1,   32'h1C,1);
        tbl[12] = mk(0,0,1,32'h2C,LW5,   1,0,4'b1111,LW5,  ADD00,LW0,  32'h20,1);
        tbl[13] = mk(0,0,1,32'h30,LUI,   1,0,4'b1111,LUI,  LW5,  ADD00,32'h24,1);
        tbl[14] = mk(0,0,1,32'h34,LW5,   1,0,4'b1111,LW5,  LUI,  LW5,  32'h28,1);
        tbl[15] = mk(0,0,1,32'h38,AI5,   1,0,4'b1111,AI5,  LW5,  LUI,  32'h2C,1);
        tbl[16] = mk(0,0,0,32'h00,32'h0, 1,0,4'b1110,NOP,  AI5,  LW5,  32'h30,1);
        tbl[17] = mk(0,0,1,32'h40,LW5,   1,0,4'b1101,LW5,  NOP,  AI5,  32'h34,1);
        tbl[18] = mk(0,0,1,32'h44,ADD,   1,0,4'b1011,ADD,  LW5,  NOP,  32'h38,1);
        tbl[19] = mk(0,1,1,32'h48,A2,    1,0,4'b0100,NOP,  NOP,  LW5,  32'h38,1);
        tbl[20] = mk(0,1,1,32'h48,A2,    1,0,4'b1000,NOP,  NOP,  NOP,  32'h40,1);
        tbl[21] = mk(0,0,1,32'h48,A2,    1,0,4'b0001,A2,   NOP,  NOP,  32'h40,1);
        tbl[22] = mk(0,0,1,32'h4C,LW5,   1,0,4'b0011,LW5,  A2,   NOP,  32'h40,1);
        tbl[23] = mk(0,0,1,32'h50,ADD,   1,0,4'b0111,ADD,  LW5,  A2,   32'h44,1);
        tbl[24] = mk(1,0,1,32'h54,A3,    0,0,4'b0111,ADD,  LW5,  A2,   32'h44,1);
        tbl[25] = mk(1,1,1,32'h54,A3,    0,0,4'b0111,ADD,  LW5,  A2,   32'h44,1);
        tbl[26] = mk(1,0,1,32'h54,A3,    0,0,4'b0111,ADD,  LW5,  A2,   32'h44,1);
        tbl[27] = mk(0,0,1,32'h54,A3,    0,1,4'b1101,ADD,  NOP,  LW5,  32'h48,2);

        halt = 0; flush = 0; if_valid = 0; if_pc = 0; if_ir = 0;
        h2 = 0; f2 = 0; iv2 = 0; pc_in2 = 0; ir_in2 = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_ir", ir_o, {4{NOP}});
        chk("rst_pc", pc_o, 128'(0));
        chk("rst_cnt", 128'(stall_cnt), 128'(0));
        reset = 1'b1;

        for (int i = 0; i < 28; i++) apply(i, tbl[i]);

        // Asynchronous reset between edges must clear state immediately.
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 128'(valid_o), 128'(0));
        chk("arst_ir", ir_o, {4{NOP}});
        chk("arst_pc", pc_o, 128'(0));
        chk("arst_cnt", 128'(stall_cnt), 128'(0));
        @(negedge clock);
        reset = 1'b1;
        apply(28, mk(0,0,1,32'h100,A4, 1,0,4'b0001,A4,NOP,NOP,32'h0,0));
        if_valid = 0;

        // Deep pipeline: STAGES=6, FLUSH_STAGE=3, CNT_W=2.
        step2(0, 1, 32'h00, A1);
        step2(0, 1, 32'h04, A2);
        step2(0, 1, 32'h08, A3);
        step2(0, 1, 32'h0C, A4);
        chk("p6_fill_valid", 128'(v2), 128'(6'b001111));
        step2(1, 1, 32'h10, A5);
        chk("p6_flush_valid", 128'(v2), 128'(6'b010000));
        chk("p6_flush_ir_lo", iro2[127:0], {4{NOP}});
        chk("p6_flush_ir4", 128'(iro2[159:128]), 128'(A1));
        chk("p6_flush_cnt", 128'(cnt2), 128'(0));
        for (int i = 0; i < 5; i++) begin
            step2(0, 1, 32'h20, LW5);
            step2(0, 1, 32'h24, ADD);
            f2 = 0; iv2 = 1; pc_in2 = 32'h28; ir_in2 = A1;
            #1;
            chk($sformatf("p6_h%0d_stall", i), 128'(stl2), 128'(1));
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("p6_h%0d_cnt", i), 128'(cnt2), 128'((i + 1 > 3) ? 3 : i + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised instruction pipeline controller for the RISC-V core. It holds the per-stage PC and IR pipeline registers with valid bits, and moves them forward every cycle. It detects load-use hazards between the RR and ALU stages and inserts bubbles for them. It also squashes younger stages on a taken-branch redirect. It sits between fetch (`pc`, instruction port) and the per-stage decoders (`rr_decoder`, `alu_decoder`, `mem_decoder`, `wb_decoder`), replacing the fixed four-entry `pc_pipe`/`ir_pipe` arrays in `cpu`.

## Interface
Parameters:
- `STAGES`, 4: number of post-fetch stages (0 = RR, 1 = ALU, 2 = MEM, 3 = WB). Legal range is 3 or more.
- `XLEN`, 32: PC width.
- `ILEN`, 32: IR width. Fixed at 32 for RV32I.
- `FLUSH_STAGE`, 1: index of the stage that resolves branches. Legal range is 1 to STAGES-2.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clock` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `halt` in 1: freezes all state.
- `if_valid` in 1: a fetched instruction is present.
- `if_pc` in XLEN: PC of the fetched instruction.
- `if_ir` in ILEN: the fetched instruction.
- `if_ready` out 1: the pipeline accepts the fetch this cycle.
- `flush` in 1: redirect issued by stage FLUSH_STAGE.
- `valid_o` out STAGES: bit k is the valid bit of stage k.
- `pc_o` out STAGES*XLEN: stage k occupies `[k*XLEN +: XLEN]`.
- `ir_o` out STAGES*ILEN: stage k occupies `[k*ILEN +: ILEN]`.
- `stall_o` out 1: a load-use stall is applied this cycle.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- **Bubble.** A bubble is a stage with valid=0, IR=NOP (0x00000013) and PC held at its previous value.
- **Hazard condition.** `hazard` is asserted when all of the following hold:
  - valid[0] and valid[1] are both set;
  - stage 1 is a LOAD (opcode 0000011);
  - rd1 (ir1[11:7]) is not 0;
  - rd1 matches a source of stage 0 under either rule:
    - rs1 (ir0[19:15]) is compared unless ir0's opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111);
    - rs2 (ir0[24:20]) is compared only when ir0's opcode is OP (0110011), STORE (0100011) or BRANCH (1100011).
- **Priority per cycle.** Conditions are checked in this order; the first that holds decides the cycle:
  1. `halt`: every register holds, the counter holds, `if_ready` = 0, `stall_o` = 0. A `flush` asserted during halt is ignored; the branch stage is frozen, so the flush is re-presented after halt releases.
  2. `flush`:
     - stages 0 to FLUSH_STAGE become bubbles;
     - stages FLUSH_STAGE+1 and above load from their predecessor;
     - `if_ready` = 1 and the fetch is consumed and dropped;
     - `hazard` is ignored and the counter does not increment.
  3. `hazard`:
     - stage 0 holds;
     - stage 1 becomes a bubble;
     - stages 2 and above advance;
     - `if_ready` = 0, `stall_o` = 1;
     - `stall_cnt` increments, saturating at 2^CNT_W-1.
  4. Normal:
     - stage k+1 loads stage k;
     - stage 0 loads {`if_valid`, `if_pc`, `if_ir`} when `if_valid`, otherwise it becomes a bubble;
     - `if_ready` = 1.
- **Invalid inputs.** An invalid stage never raises a hazard.
- **Write-back.** The last stage's contents are dropped on the next advance.

## Timing
- **Reset values.** While `reset` is low: `valid_o` = 0, every IR = NOP, every PC = 0, `stall_cnt` = 0.
- **Reset release.** The first edge after release behaves as a normal cycle.
- **Reset mid-operation.** All in-flight instructions are lost; no partial state survives.
- **Latency.** An instruction accepted at edge t is visible in stage k after edge t+k, plus one cycle per hazard stall it experiences while in stage 0.
- **Registered outputs.** `valid_o`, `pc_o`, `ir_o` and `stall_cnt` come straight from registers.
- **Combinational outputs.** `if_ready` and `stall_o` are combinational from the current stage state, `halt` and `flush`.
- **Back-to-back flushes.** Legal. Each flush squashes the stages as above; stages that are already bubbles stay bubbles.
- **Hazard after a load.** A hazard lasts exactly one cycle for a given load, because the load moves to stage 2 and a bubble takes its place in stage 1.

## Structure
- **Shared package `pipe_pkg`:**
  - `NOP` constant;
  - opcode constants (LOAD, OP, STORE, BRANCH, LUI, AUIPC, JAL);
  - field-slice constants for rd, rs1, rs2 and opcode.
- **Sub-module `hazard_detect`:** combinational block taking ir0, ir1, valid[1:0] and producing `hazard`.
- **Stage registers:** all stage registers live in `pipe_ctrl`, built with a generate loop over STAGES.

## Test plan
- **Normal flow.** After reset, feed 6 valid fetches with PC 0x0 to 0x14, one per cycle, all ADDI instructions. Required: `pc_o` stage 3 shows 0x0 after the 4th edge; no stalls occur.
- **Load-use hazard.** `lw x5,0(x1)` followed by `add x6,x5,x2`. Required: one cycle with `stall_o` = 1 and `if_ready` = 0; stage 1 becomes NOP with valid=0; `stall_cnt` = 1; the add reaches stage 1 one cycle late.
- **No false hazards.** `lw x0,0(x1)` followed by `add x6,x0,x0`, and `lw x5` followed by `lui x5`. Required: neither pair stalls.
- **Flush priority.** Assert `flush` while a hazard is present, with FLUSH_STAGE=1. Required: stages 0 and 1 become bubbles; `stall_cnt` is unchanged; the stage 1 instruction (the branch) appears in stage 2.
- **Halt.** Assert `halt` for 3 cycles mid-stream, with `flush` asserted on the 2nd. Required: all outputs are frozen and the flush is ignored. Then assert reset asynchronously between edges. Required: `valid_o` = 0 and IRs = NOP without waiting for a clock edge.
- **Parameter variant.** STAGES=6, FLUSH_STAGE=3, CNT_W=2. Required: a flush bubbles stages 0 to 3; after 5 hazards `stall_cnt` saturates at 3.
